// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter with bounded bursts in front of a registered 2:1 select stage.
// Optional MUX_ARB_FIXED_PRIO_EN: fixed priority to A; B yields to A after MAX_BURST words.
module mux_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] A,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] B,
  output logic             ack_b,
  output logic             sel,
  output logic [WIDTH-1:0] X,
  output logic             x_valid,
  input  logic             x_ready
);

  localparam int unsigned        CNT_W      = 4;
  localparam logic [CNT_W-1:0]   BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic               SEL_A      = 1'b0;
  localparam logic               SEL_B      = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e             state_q;
  logic               sel_q;
  logic               x_valid_q;
  logic [WIDTH-1:0]   x_q;
  logic [CNT_W-1:0]   burst_q;
  logic               slot_free;
  logic               accept_a;
  logic               accept_b;
  logic               burst_at_max;
  logic               prio_a;

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign prio_a = 1'b1;
`else
  // last accepted source; A wins a tie only if B went last
  logic last_q;
  assign prio_a = (last_q == SEL_B);
`endif

  // Accept decisions come from the registered grant so acks never glitch across sources
  always_comb begin
    slot_free    = !x_valid_q || x_ready;
    accept_a     = (state_q == GRANT_A) && req_a && slot_free;
    accept_b     = (state_q == GRANT_B) && req_b && slot_free;
    burst_at_max = (burst_q == BURST_LAST);
  end

  assign ack_a   = accept_a;
  assign ack_b   = accept_b;
  assign sel     = sel_q;
  assign X       = x_q;
  assign x_valid = x_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= SEL_A;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      burst_q   <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      last_q    <= SEL_B;
`endif
    end else begin
      // Output stage: load on accept, otherwise drain when the sink takes the word
      if (accept_a) begin
        x_q       <= A;
        x_valid_q <= 1'b1;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_q    <= SEL_A;
`endif
      end else if (accept_b) begin
        x_q       <= B;
        x_valid_q <= 1'b1;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_q    <= SEL_B;
`endif
      end else if (x_ready) begin
        x_valid_q <= 1'b0;
      end

      if ((accept_a || accept_b) && !burst_at_max) begin
        burst_q <= burst_q + CNT_W'(1);
      end

      // Grant transitions; a transition into a GRANT state restarts the burst
      case (state_q)
        IDLE: begin
          if (req_a && (!req_b || prio_a)) begin
            state_q <= GRANT_A;
            sel_q   <= SEL_A;
            burst_q <= '0;
          end else if (req_b) begin
            state_q <= GRANT_B;
            sel_q   <= SEL_B;
            burst_q <= '0;
          end
        end
        GRANT_A: begin
          if (!req_a) begin
            if (req_b) begin
              state_q <= GRANT_B;
              sel_q   <= SEL_B;
              burst_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
`ifndef MUX_ARB_FIXED_PRIO_EN
          else if (accept_a && burst_at_max && req_b) begin
            state_q <= GRANT_B;
            sel_q   <= SEL_B;
            burst_q <= '0;
          end
`endif
        end
        GRANT_B: begin
          if (!req_b) begin
            if (req_a) begin
              state_q <= GRANT_A;
              sel_q   <= SEL_A;
              burst_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (accept_b && burst_at_max && req_a) begin
            state_q <= GRANT_A;
            sel_q   <= SEL_A;
            burst_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
